// File: rtl/phy_tx.sv
// -----------------------------------------------------------------------------
// phy_tx -- transmit-side PHY for the two-lane serial link.
//
// This block takes 32-bit words on a valid/ready handshake and splits each word
// into bytes. Lane 0 carries bytes [31:24] and then [15:8]. Lane 1 carries bytes
// [23:16] and then [7:0]. Each lane sends its bytes MSB-first, one bit per
// clk_32f cycle.
//
// After reset, both lanes send a training burst of SYNC_BYTES comma bytes
// (0xBC) each. The receiver aligns to this burst. After training, a word slot
// with no data to send carries idle bytes (0x7C).
//
// Optional feature (compile-time macro PHY_TX_RESYNC_EN):
//   After every RESYNC_PERIOD ACTIVE word slots, the next slot is a forced
//   comma slot. Both lanes send 0xBC for the whole slot. The held word stays in
//   place during that slot.
//
// Parameters:
//   SYNC_BYTES    : comma bytes per lane after reset (even, 2..254)
//   RESYNC_PERIOD : word slots between forced comma slots (1..255)
//
// Ports:
//   clk_32f    in   bit clock; every state change happens on its rising edge
//   reset      in   synchronous, active-high
//   data_in    in   32-bit word to transmit
//   valid_in   in   data_in is valid
//   ready_out  out  a word can be accepted this cycle
//   data_out_0 out  serial lane 0
//   data_out_1 out  serial lane 1
//   active_out out  training is finished; the lanes carry data or idle
// -----------------------------------------------------------------------------
module phy_tx #(
    parameter int SYNC_BYTES    = 8,
    parameter int RESYNC_PERIOD = 64
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        data_out_0,
    output logic        data_out_1,
    output logic        active_out
);

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [7:0] COMMA     = 8'hBC;
    localparam logic [7:0] IDLE      = 8'h7C;
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_BYTES);

    // Reject parameter values outside the supported ranges when the design is
    // elaborated.
    if (SYNC_BYTES < 2 || SYNC_BYTES > 254 || (SYNC_BYTES % 2) != 0 ||
        RESYNC_PERIOD < 1 || RESYNC_PERIOD > 255) begin : g_param_check
        $error("phy_tx: SYNC_BYTES or RESYNC_PERIOD out of range");
    end

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [7:0]  sync_cnt_reg;
    logic [7:0]  sh_reg [2];     // index 0 = lane 0, index 1 = lane 1
    logic [15:0] lo_reg;
    logic [31:0] hold_reg;
    logic        hold_v_reg;

    logic        word_edge;
    logic        mid_edge;
    logic        sync_edge;
    logic        forced_comma;
    logic        load_now;
    logic        accept;
    logic [1:0]  lane_bits;

    // Word-load boundary. This includes the final training boundary, because
    // the transition to ACTIVE also performs the first word load.
    assign word_edge = (cnt_reg == 4'd15) &&
                       ((state_reg == ACTIVE) || (sync_cnt_reg == SYNC_LAST));
    assign mid_edge  = (cnt_reg == 4'd7) && (state_reg == ACTIVE);
    assign sync_edge = (state_reg == SYNC) && !word_edge &&
                       ((cnt_reg == 4'd7) || (cnt_reg == 4'd15));

`ifdef PHY_TX_RESYNC_EN
    localparam logic [7:0] RESYNC_LAST = 8'(RESYNC_PERIOD);

    // Counts the word slots loaded since the last forced comma slot.
    logic [7:0] slot_cnt_reg;

    assign forced_comma = (slot_cnt_reg == RESYNC_LAST);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            slot_cnt_reg <= 8'd0;
        end else if (word_edge) begin
            if (forced_comma) begin
                slot_cnt_reg <= 8'd0;
            end else begin
                slot_cnt_reg <= slot_cnt_reg + 8'd1;
            end
        end
    end
`else
    assign forced_comma = 1'b0;
`endif

    assign load_now  = word_edge && hold_v_reg && !forced_comma;
    assign ready_out = !reset && (!hold_v_reg || load_now);
    assign accept    = valid_in && ready_out;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_reg    <= SYNC;
            cnt_reg      <= 4'd15;
            sync_cnt_reg <= 8'd0;
            sh_reg[0]    <= 8'd0;
            sh_reg[1]    <= 8'd0;
            lo_reg       <= 16'd0;
            hold_v_reg   <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + 4'd1;

            // If a word is loaded and another is accepted on the same edge, the
            // old word goes to the lanes and the new word takes its place in
            // hold. No slot is left empty.
            if (accept) begin
                hold_reg   <= data_in;
                hold_v_reg <= 1'b1;
            end else if (load_now) begin
                hold_v_reg <= 1'b0;
            end

            if (word_edge) begin
                state_reg <= ACTIVE;
                if (forced_comma) begin
                    sh_reg[0] <= COMMA;
                    sh_reg[1] <= COMMA;
                    lo_reg    <= {COMMA, COMMA};
                end else if (hold_v_reg) begin
                    sh_reg[0] <= hold_reg[31:24];
                    sh_reg[1] <= hold_reg[23:16];
                    lo_reg    <= hold_reg[15:0];
                end else begin
                    sh_reg[0] <= IDLE;
                    sh_reg[1] <= IDLE;
                    lo_reg    <= {IDLE, IDLE};
                end
            end else if (mid_edge) begin
                sh_reg[0] <= lo_reg[15:8];
                sh_reg[1] <= lo_reg[7:0];
            end else if (sync_edge) begin
                sh_reg[0]    <= COMMA;
                sh_reg[1]    <= COMMA;
                sync_cnt_reg <= sync_cnt_reg + 8'd1;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    sh_reg[i] <= {sh_reg[i][6:0], 1'b0};
                end
            end
        end
    end

    // Each lane transmits the MSB of its shift register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign lane_bits[gi] = sh_reg[gi][7];
    end

    assign data_out_0 = lane_bits[0];
    assign data_out_1 = lane_bits[1];
    assign active_out = (state_reg == ACTIVE);

endmodule

// File: tb/tb_phy_tx.sv
// -----------------------------------------------------------------------------
// tb_phy_tx -- self-checking bench for phy_tx.
//
// A slot-level reference runs on the falling clock edge. Before each rising
// edge it predicts ready_out and which bytes that edge loads, and it pushes the
// expected bytes into per-lane queues. A lane monitor rebuilds bytes from the
// serial bits. After eight bits it pops the queue and compares the byte.
// Build with PHY_TX_RESYNC_EN defined to check forced comma slots; that build
// uses RESYNC_PERIOD=4.
// -----------------------------------------------------------------------------
module tb_phy_tx;

    localparam int SB = 8;
`ifdef PHY_TX_RESYNC_EN
    localparam int RP     = 4;
    localparam bit RES_EN = 1'b1;
`else
    localparam int RP     = 64;
    localparam bit RES_EN = 1'b0;
`endif

    logic        clk_32f  = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] data_in  = 32'd0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        data_out_0;
    logic        data_out_1;
    logic        active_out;

    int checks = 0;
    int errors = 0;

    phy_tx #(
        .SYNC_BYTES   (SB),
        .RESYNC_PERIOD(RP)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out_0(data_out_0),
        .data_out_1(data_out_1),
        .active_out(active_out)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %08h want %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    int          m_edge      = 0;
    bit          m_prev_reset = 1'b1;
    logic [31:0] m_hold      = 32'd0;
    bit          m_hold_v    = 1'b0;
    logic [15:0] m_lo        = 16'd0;
    int          m_slot      = 0;
    logic [7:0]  exp0_q[$];
    logic [7:0]  exp1_q[$];
    logic [7:0]  b0 = 8'd0;
    logic [7:0]  b1 = 8'd0;
    logic [7:0]  e0;
    logic [7:0]  e1;
    bit          word_edge, forced, consume, exp_ready;

    always @(negedge clk_32f) begin
        if (reset) begin
            check_val("ready_in_reset", 32'(ready_out), 32'd0);
            if (m_prev_reset) begin
                check_val("lanes_in_reset", 32'({data_out_1, data_out_0}), 32'd0);
                check_val("active_in_reset", 32'(active_out), 32'd0);
            end
            m_edge   = 0;
            m_hold_v = 1'b0;
            m_lo     = 16'd0;
            m_slot   = 0;
            exp0_q.delete();
            exp1_q.delete();
            b0 = 8'd0;
            b1 = 8'd0;
        end else begin
            // Lane outputs now show the state left by edge m_edge-1.
            if (m_edge == 0) begin
                check_val("lanes_after_reset", 32'({data_out_1, data_out_0}), 32'd0);
            end else begin
                b0 = {b0[6:0], data_out_0};
                b1 = {b1[6:0], data_out_1};
                if ((m_edge - 1) % 8 == 7) begin
                    check_val("lane_queue_depth", 32'(exp0_q.size() > 0 && exp1_q.size() > 0), 32'd1);
                    if (exp0_q.size() > 0 && exp1_q.size() > 0) begin
                        e0 = exp0_q.pop_front();
                        e1 = exp1_q.pop_front();
                        $display("byte at edge %0d: lane0 %02h (exp %02h) lane1 %02h (exp %02h)",
                                 m_edge - 8, b0, e0, b1, e1);
                        check_val("lane0_byte", 32'(b0), 32'(e0));
                        check_val("lane1_byte", 32'(b1), 32'(e1));
                    end
                end
            end
            check_val("active_out", 32'(active_out), 32'((m_edge - 1) >= 8 * SB));

            // Predict the upcoming rising edge, number m_edge.
            word_edge = (m_edge >= 8 * SB) && ((m_edge - 8 * SB) % 16 == 0);
            forced    = RES_EN && word_edge && (m_slot == RP);
            consume   = word_edge && !forced && m_hold_v;
            exp_ready = !m_hold_v || consume;
            check_val("ready_out", 32'(ready_out), 32'(exp_ready));

            if (m_edge < 8 * SB) begin
                if (m_edge % 8 == 0) begin
                    exp0_q.push_back(8'hBC);
                    exp1_q.push_back(8'hBC);
                end
            end else if (word_edge) begin
                if (forced) begin
                    exp0_q.push_back(8'hBC);
                    exp1_q.push_back(8'hBC);
                    m_lo   = 16'hBCBC;
                    m_slot = 0;
                end else begin
                    if (consume) begin
                        exp0_q.push_back(m_hold[31:24]);
                        exp1_q.push_back(m_hold[23:16]);
                        m_lo = m_hold[15:0];
                    end else begin
                        exp0_q.push_back(8'h7C);
                        exp1_q.push_back(8'h7C);
                        m_lo = 16'h7C7C;
                    end
                    m_slot++;
                end
            end else if ((m_edge - 8 * SB) % 16 == 8) begin
                exp0_q.push_back(m_lo[15:8]);
                exp1_q.push_back(m_lo[7:0]);
            end

            if (consume) m_hold_v = 1'b0;
            if (valid_in && exp_ready) begin
                m_hold   = data_in;
                m_hold_v = 1'b1;
            end
            m_edge++;
        end
        m_prev_reset = reset;
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_32f);
        #1;
    endtask

    // Presents w and keeps valid_in high until an edge accepts it. On return
    // valid_in is still high, so a following call continues back-to-back.
    task automatic send(input logic [31:0] w, output int cycles);
        bit took;
        took   = 1'b0;
        cycles = 0;
        data_in  = w;
        valid_in = 1'b1;
        while (!took && cycles < 200) begin
            @(negedge clk_32f);
            took = ready_out;
            @(posedge clk_32f);
            #1;
            cycles++;
        end
        check_val("send_accepted", 32'(took), 32'd1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
    endtask

    int cyc;
    int guard;

    initial begin
        // Reset, then idle: training burst followed by idle bytes.
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(100);

        // Single word.
        send(32'hDEADBEEF, cyc);
        valid_in = 1'b0;
        wait_cycles(40);

        // Back-to-back words.
        send(32'h01020304, cyc);
        send(32'h05060708, cyc);
        send(32'h090A0B0C, cyc);
        valid_in = 1'b0;
        wait_cycles(50);

        // Continuous stream; in the resync build this spans forced comma slots.
        for (int i = 0; i < 12; i++) begin
            send($urandom, cyc);
        end
        valid_in = 1'b0;
        wait_cycles(60);

        // Early data during training.
        do_reset();
        wait_cycles(10);
        send(32'h11223344, cyc);
        check_val("early_accept_cycles", 32'(cyc), 32'd1);
        valid_in = 1'b0;
        wait_cycles(100);

        // Reset in the middle of a word. Word A is on the lanes and word B
        // waits in hold; B must never appear.
        do_reset();
        send(32'hCAFEF00D, cyc);
        send(32'h0BADC0DE, cyc);
        valid_in = 1'b0;
        guard = 0;
        while (m_edge != 69 && guard < 300) begin
            @(posedge clk_32f);
            #1;
            guard++;
        end
        check_val("reach_cnt4_edge", 32'(m_edge), 32'd69);
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phy_tx.md
# phy_tx

- Transmit-side PHY for the two-lane serial link.
- Accepts 32-bit words over a valid/ready handshake and byte-stripes each word across two lanes.
- Serializes the lanes MSB-first at one bit per `clk_32f` cycle.
- After reset, sends a comma (0xBC) training burst; the receive PHY's `sincronizar_bus` locks on it. Idle word slots carry 0x7C.

## Interface
- `SYNC_BYTES`, 8: comma bytes per lane sent after reset. Must be even, range 2..254.
- `RESYNC_PERIOD`, 64: word slots between forced comma slots. Used only with `PHY_TX_RESYNC_EN`. Range 1..255.
- `clk_32f` in 1: bit clock. The only clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `data_in` in 32: word to transmit.
- `valid_in` in 1: `data_in` is valid.
- `ready_out` out 1: block can accept a word this cycle.
- `data_out_0` out 1: serial lane 0.
- `data_out_1` out 1: serial lane 1.
- `active_out` out 1: training finished; lanes carry data or idle.

## Operation
- **State**
  - `state` ∈ {SYNC, ACTIVE}.
  - 4-bit slot counter `cnt`, wraps 15→0.
  - 8-bit `sync_cnt`.
  - Per lane, an 8-bit shift register: `sh0`, `sh1`.
  - 16-bit low-half register `lo`.
  - One-entry holding register `hold` with flag `hold_v`.
- **Serial path**
  - Lane outputs: `data_out_0 = sh0[7]`, `data_out_1 = sh1[7]`.
  - On a non-boundary cycle, each shift register shifts left by one, filling 0.
- **Byte boundaries**
  - Boundaries occur at `cnt==7` and `cnt==15`.
  - At a boundary, the shift registers load a new byte instead of shifting.
- **SYNC state**
  - Every boundary loads 0xBC into both lanes and increments `sync_cnt`.
  - At the `cnt==15` boundary where `sync_cnt==SYNC_BYTES`, the state moves to ACTIVE, and that same boundary performs the ACTIVE word load.
- **ACTIVE state, `cnt==15` (word load)**
  - If `hold_v`: `sh0←hold[31:24]`, `sh1←hold[23:16]`, `lo←hold[15:0]`, and `hold_v` clears.
  - Otherwise: both lanes load 0x7C and `lo←16'h7C7C`.
- **ACTIVE state, `cnt==7`**
  - `sh0←lo[15:8]`, `sh1←lo[7:0]`.
- **Handshake**
  - `ready_out = !reset && (!hold_v || load_now)`.
  - `load_now` is the ACTIVE `cnt==15` cycle that consumes `hold`.
  - Accept when `valid_in && ready_out`: `hold←data_in`, `hold_v←1`.
  - Simultaneous load and accept: the old word goes to the lanes and the new word occupies `hold`, with no bubble.
  - Words may be accepted during SYNC. They wait in `hold` until the first ACTIVE load.
- **Content**
  - Data bytes equal to 0xBC or 0x7C are sent unchanged.
  - Avoiding them is the upper layer's responsibility.

## Timing
- **Reset values:** `state=SYNC`, `cnt=15`, `sync_cnt=0`, `sh0=sh1=0`, `lo=0`, `hold_v=0`.
  - Resulting outputs: `data_out_0=data_out_1=0`, `active_out=0`, `ready_out=0` while `reset` is high.
- **Reset mid-operation:** all state returns to the reset values and the held word is discarded. Training restarts.
- **Edge numbering:** edge 0 is the first edge after `reset` deasserts.
  - Boundaries fall on edges 0, 8, 16, …
  - Comma bytes are loaded at edges 0 … 8·(SYNC_BYTES−1).
  - The first word or idle load is at edge 8·SYNC_BYTES (64 by default).
  - `active_out` rises after that edge.
- **Throughput:** one word per 16 cycles.
- **Latency:** a word accepted while `hold` is empty in ACTIVE appears on the lanes (first bit) 1–16 cycles later, after the next `cnt==15` edge.
- **Lane timing:** lane 0 carries bit 31 while lane 1 carries bit 23, and the two lanes stay bit-aligned.

## Configuration
- **`PHY_TX_RESYNC_EN` defined**
  - In ACTIVE, an 8-bit word-slot counter counts loads.
  - The slot after every `RESYNC_PERIOD` slots is a forced comma slot: both lanes carry 0xBC at both boundaries.
  - During a forced comma slot, `hold` is not consumed and `ready_out` follows `!hold_v` only.
  - The slot counter resets to 0 with `reset`.
- **`PHY_TX_RESYNC_EN` undefined**
  - No forced comma slots; every ACTIVE slot carries data or idle.

## Test plan
- **Reset then idle:** deassert `reset` with `valid_in=0`.
  - Lanes carry 8 bytes of 0xBC each (bit pattern 10111100).
  - Then 0x7C repeats on both lanes.
  - `active_out` rises after edge 64.
- **Single word:** send 0xDEADBEEF once ACTIVE.
  - Lane 0 carries 0xDE then 0xBE; lane 1 carries 0xAD then 0xEF.
  - Idle 0x7C resumes after.
- **Back-to-back:** hold `valid_in=1` with words 0x01020304, 0x05060708, 0x090A0B0C.
  - `ready_out` drops for 15 of every 16 cycles.
  - The three words go out in consecutive slots with no idle in between.
- **Early data:** present 0x11223344 during SYNC.
  - It is accepted immediately and `ready_out` goes to 0.
  - It is sent in the first ACTIVE slot.
- **Reset mid-word:** assert `reset` at `cnt==4` of a data slot.
  - Outputs are 0 next cycle.
  - Training restarts and the held word is never sent.
- **`PHY_TX_RESYNC_EN` with `RESYNC_PERIOD=4`:** stream continuously.
  - Every 5th slot is all 0xBC.
  - No data word is lost or duplicated.
